hex_display_scanner: RTL and testbench
======================================

// Module: hex_display_scanner
// PURPOSE
//  Downstream consumer of the cyber_cobra register-file read port (OUT_RD1).
//  Time-multiplexes a WIDTH-bit value onto a common-anode 8-digit 7-segment display as hex.
//  Takes a snapshot of the value once per full scan frame, so a frame never shows a torn value.
//  Sits between the core top and the board pins.
// PARAMETERS
//  WIDTH    32     input value width; must be a multiple of 4; DIGITS = WIDTH/4 (localparam)
//  CLK_DIV  50000  clk cycles each digit stays lit; must be >= 2
// PORTS
//  clk      input   1        system clock, rising edge
//  rst      input   1        asynchronous, active-low reset
//  data_i   input   WIDTH    value to display (connect to OUT_RD1)
//  an_o     output  DIGITS   digit enables, active-low, one-hot-zero; bit k = nibble k
//  seg_o    output  7        segments {g,f,e,d,c,b,a}, active-low
//  frame_o  output  1        1-cycle pulse when a new snapshot becomes visible
// BEHAVIOUR
//  - Reset (rst=0, async, effective immediately, also mid-scan):
//    - div=0, idx=0, snap=0
//    - an_o='1 (all dark), seg_o=7'h7F, frame_o=0
//  - Divider:
//    - div counts 0..CLK_DIV-1
//    - tick = (div==CLK_DIV-1); on tick div<=0, otherwise div<=div+1
//  - Digit index:
//    - On tick, idx<=idx+1; wraps DIGITS-1 -> 0
//    - Wrap tick (idx==DIGITS-1 && tick): snap<=data_i and frame_o<=1 on the same edge;
//      frame_o is 0 on all other cycles
//    - data_i is sampled only on the wrap tick; changes between wrap ticks are ignored
//  - Outputs:
//    - Registered, 1-cycle lag behind idx/snap
//    - an_o <= ~(1<<idx)
//    - seg_o <= hex7(snap[4*idx+:4])
//    - First edge after reset release: an_o=...FE, seg_o=7'h40
//  - hex7 table (active-low, hex), nibble 0..F:
//    40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E
//  - Timing: frame period = DIGITS*CLK_DIV cycles; frame_o period identical
//  - Counters are sized $clog2(CLK_DIV) and $clog2(DIGITS); no overflow past terminal values
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - Digit k>0 is blanked (an_o bit k=1, seg_o=7'h7F) when snap[WIDTH-1:4*k]==0
//    - Digit 0 is never blanked, so a value of 0 shows a single '0'
//    - Blanking is evaluated on snap, with the same 1-cycle output lag
//  LEADING_ZERO_BLANK_EN undefined:
//    - All DIGITS digits are always scanned, leading zeros shown
// TESTING  (bench: WIDTH=32, CLK_DIV=4, frame = 32 cycles)
//  1. Reset:
//     - rst=0 -> an_o=8'hFF, seg_o=7'h7F, frame_o=0
//     - Release; first edge -> an_o=8'hFE, seg_o=7'h40
//     - Each digit holds for 4 cycles
//  2. Scan:
//     - Hold data_i=32'h0123_4567
//     - frame_o pulses once at cycle 32 after release
//     - Then an_o steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles,
//       with seg_o 78,02,12,19,30,24,79,40
//     - Repeats; frame_o pulses every 32 cycles
//  3. Snapshot coherence:
//     - Switch data_i to 32'h89AB_CDEF while digit 3 is lit
//     - The rest of the current frame still shows 0123_4567
//     - Next frame seg_o: 0E,06,21,46,03,08,10,00
//  4. Reset mid-scan:
//     - Drop rst while digit 5 is lit, asynchronously between edges
//     - an_o=8'hFF and seg_o=7'h7F immediately
//     - After release, scan restarts at digit 0 showing 40 (snap cleared)
//  5. Wrap / divider boundary:
//     - frame_o is never asserted on two consecutive cycles
//     - an_o always has exactly one 0 bit after the first post-reset edge
//     - Counters never exceed 3 (div) and 7 (idx)
//  6. LEADING_ZERO_BLANK_EN:
//     - data_i=32'h0000_00A5 -> digit0 seg 12, digit1 seg 08, digits 2..7 an_o bit=1, seg 7F
//     - data_i=0 -> only digit 0 lit, showing 40

Source files
------------

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexes a WIDTH-bit value onto a common-anode 7-segment display
//   as hex digits. The value is snapshotted once per full scan frame, on the
//   edge where the digit index wraps back to 0, so one frame never mixes
//   nibbles from two different input values.
//
// Parameters
//   WIDTH    value width, multiple of 4; DIGITS = WIDTH/4
//   CLK_DIV  clk cycles each digit stays lit, >= 2
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   data_i   value to display
//   an_o     digit enables, active-low, bit k drives nibble k
//   seg_o    segments {g,f,e,d,c,b,a}, active-low
//   frame_o  one-cycle pulse on the edge that loads a new snapshot
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          non-zero nibble are dark; digit 0 is always lit.

module hex_display_scanner #(
   parameter int WIDTH   = 32,
   parameter int CLK_DIV = 50000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   data_i,
   output logic [WIDTH/4-1:0] an_o,
   output logic [6:0]         seg_o,
   output logic               frame_o
);

   localparam int DIGITS = WIDTH / 4;
   localparam int DW     = $clog2(CLK_DIV);
   localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [DW-1:0]     div;
   logic [IW-1:0]     idx;
   logic [WIDTH-1:0]  snap;
   logic              tick;
   logic              last_digit;
   logic [3:0]        nibble;
   logic [DIGITS-1:0] an_next;
   logic [6:0]        seg_next;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick       = (div == DW'(CLK_DIV - 1));
   assign last_digit = (idx == IW'(DIGITS - 1));

   // Divider, digit index and snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div     <= '0;
         idx     <= '0;
         snap    <= '0;
         frame_o <= 1'b0;
      end else begin
         frame_o <= 1'b0;
         if (tick) begin
            div <= '0;
            if (last_digit) begin
               idx     <= '0;
               snap    <= data_i;
               frame_o <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // Digit decode from the current idx/snap; registered below, so the pins
   // lag idx by one cycle.
   always_comb begin
      nibble   = 4'(snap >> {idx, 2'b00});
      an_next  = ~(DIGITS'(1) << idx);
      seg_next = hex7(nibble);
`ifdef LEADING_ZERO_BLANK_EN
      begin
         logic [DIGITS-1:0] blank_vec;
         blank_vec    = '0;
         // Digit k is a leading zero when every nibble from k upward is 0.
         for (int k = 1; k < DIGITS; k++) begin
            blank_vec[k] = ((snap >> (4 * k)) == '0);
         end
         if (blank_vec[idx]) begin
            an_next  = '1;
            seg_next = 7'h7F;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_o  <= '1;
         seg_o <= 7'h7F;
      end else begin
         an_o  <= an_next;
         seg_o <= seg_next;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner
//   Directed bench for hex_display_scanner with WIDTH=32, CLK_DIV=4.
//   The stimulus process queues the expected pin state for each cycle
//   (counted in rising edges since reset release); the monitor process pops
//   and compares on the falling edge and also watches pin invariants.

`timescale 1ns/1ps

module tb_hex_display_scanner;

   localparam int WIDTH   = 32;
   localparam int CLK_DIV = 4;

   // Per-digit segment tables, packed {digit7, ..., digit0}.
   localparam logic [55:0] TAB_Z  = {8{7'h40}};
   localparam logic [55:0] TAB_A  = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
   localparam logic [55:0] TAB_B  = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   localparam logic [55:0] TAB_A5 = {{6{7'h7F}}, 7'h08, 7'h12};

`ifdef LEADING_ZERO_BLANK_EN
   localparam int LIT_Z = 1;
   localparam int LIT_A = 7;
`else
   localparam int LIT_Z = 8;
   localparam int LIT_A = 8;
`endif

   typedef struct {
      int         cyc;
      logic [7:0] an;
      logic [6:0] seg;
      logic       frame;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] data_i;
   logic [7:0]       an_o;
   logic [6:0]       seg_o;
   logic             frame_o;

   exp_t q[$];
   int   cyc;
   int   n_checks;
   int   n_fail;
   logic prev_frame;

   hex_display_scanner #(
      .WIDTH   (WIDTH),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .an_o    (an_o),
      .seg_o   (seg_o),
      .frame_o (frame_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endfunction

   task automatic push_frame(input int start, input logic [55:0] tab, input int lit, input int last);
      for (int c = start; c <= last; c++) begin
         exp_t e;
         int   d;
         d     = ((c - start) / CLK_DIV) % 8;
         e.cyc = c;
         if (d < lit) begin
            e.an  = ~(8'h01 << d);
            e.seg = tab[7*d +: 7];
         end else begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
         end
         e.frame = (c == start + 31);
         q.push_back(e);
      end
   endtask

   task automatic wait_cyc(input int k);
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (cyc == k) break;
      end
      check("reach_cyc", cyc, k);
   endtask

   // Edge counter since reset release.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Monitor: pop and compare the entry stamped with the current cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst && cyc > 0) begin
         while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("stale_stamp", e.cyc, cyc);
         end
         if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            check("an_o", an_o, e.an);
            check("seg_o", seg_o, e.seg);
            check("frame_o", frame_o, e.frame);
         end
`ifdef LEADING_ZERO_BLANK_EN
         check("an_at_most_one_low", ($countones(~an_o) <= 1), 1);
`else
         check("an_one_low", $countones(~an_o), 1);
`endif
         check("frame_not_back_to_back", (frame_o && prev_frame), 0);
         prev_frame = frame_o;
      end else begin
         prev_frame = 1'b0;
      end
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      prev_frame = 1'b0;
      data_i     = 32'h0123_4567;
      rst        = 1'b1;
      #1 rst     = 1'b0;
      #11;
      check("reset_an", an_o, 8'hFF);
      check("reset_seg", seg_o, 7'h7F);
      check("reset_frame", frame_o, 0);

      // Frame 0 shows the cleared snapshot, then 0123_4567, then 89AB_CDEF.
      push_frame(1, TAB_Z, LIT_Z, 32);
      push_frame(33, TAB_A, LIT_A, 64);
      push_frame(65, TAB_B, 8, 96);
      push_frame(97, TAB_B, 8, 118);
      @(negedge clk);
      rst = 1'b1;

      // Change input while digit 3 of frame 1 is lit; frame 1 must not tear.
      wait_cyc(46);
      data_i = 32'h89AB_CDEF;

      // Drop reset asynchronously while digit 5 is lit.
      wait_cyc(118);
      #3 rst = 1'b0;
      #1;
      check("midscan_an", an_o, 8'hFF);
      check("midscan_seg", seg_o, 7'h7F);
      check("midscan_frame", frame_o, 0);
      repeat (2) @(negedge clk);
      push_frame(1, TAB_Z, LIT_Z, 32);
      push_frame(33, TAB_B, 8, 64);
      rst = 1'b1;
      wait_cyc(50);

`ifdef LEADING_ZERO_BLANK_EN
      data_i = 32'h0000_00A5;
      push_frame(65, TAB_A5, 2, 96);
      wait_cyc(70);
      data_i = 32'h0;
      push_frame(97, TAB_Z, 1, 128);
      wait_cyc(128);
`else
      wait_cyc(64);
`endif

      @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
